pc_sequencer: RTL and testbench

- Next-generation program-counter unit for the MIPS core: owns the PC register and the next-PC selection.
- Extends the existing next-PC select with BNE, JAL, JR and JALR handling, an exception vector, and a stall hold.
- Adds a parametrised return-address stack (RAS). The RAS predicts JR/JALR targets and counts mispredictions.
- Sits between instruction fetch and decode. The branch and jump target adders stay outside this block.

---
 rtl/pc_sequencer_pkg.sv | 27 ++
 rtl/pc_sequencer_ras_stack.sv | 56 +++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared MIPS opcode/funct constants and next-PC select encoding.
package pc_sequencer_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;

    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_REG,
        SEL_EXC,
        SEL_HOLD
    } pc_sel_e;

    // A branch is taken on equality for BEQ and on inequality for BNE.
    function automatic logic branch_taken(input logic [5:0] op, input logic zero);
        return ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
    endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry; a simultaneous pop+push on a non-empty stack replaces the top.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic             pop_eff;
    logic             replace;
    logic [PTR_W-1:0] wr_idx;

    assign valid   = (count != '0);
    assign pop_eff = pop && valid;
    assign replace = push && pop_eff;
    assign wr_idx  = replace ? ptr : ptr + PTR_W'(1);
    assign top     = valid ? mem[ptr] : '0;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (replace) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CW'(DEPTH))
                count <= count + CW'(1);
        end else if (pop_eff) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care while the stack is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register with next-PC selection, RAS-based return
// prediction for JR/JALR and a saturating mispredict counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter int              RAS_DEPTH  = 4,
    parameter int              CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       exc_req,
    input  logic [5:0]                 opcode,
    input  logic [5:0]                 funct,
    input  logic                       rs_is_ra,
    input  logic                       zero_flag,
    input  logic [ADDR_W-1:0]          bpc,
    input  logic [ADDR_W-1:0]          jpc,
    input  logic [ADDR_W-1:0]          rpc,
    output logic [ADDR_W-1:0]          pc,
    output logic [ADDR_W-1:0]          npc,
    output logic [ADDR_W-1:0]          ra_pred,
    output logic                       ra_pred_valid,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic [CNT_W-1:0]           mispredict_cnt
);

    logic        is_special;
    logic        is_jr;
    logic        is_jalr;
    logic        is_jal;
    logic        is_jump;
    logic        update;
    logic        ras_push;
    logic        ras_pop;
    logic        mispredict;
    pc_sel_e     sel;
    logic [ADDR_W-1:0] next_pc;

    assign npc        = pc + ADDR_W'(4);
    assign is_special = (opcode == OP_SPECIAL);
    assign is_jr      = is_special && (funct == FUNCT_JR);
    assign is_jalr    = is_special && (funct == FUNCT_JALR);
    assign is_jal     = (opcode == OP_JAL);
    assign is_jump    = (opcode == OP_J) || is_jal;
    assign update     = !exc_req && !stall;

    // RAS traffic only happens on cycles where the PC actually advances.
    assign ras_push   = update && (is_jal || is_jalr);
    assign ras_pop    = update && (is_jr || is_jalr) && rs_is_ra;
    assign mispredict = ras_pop && ra_pred_valid && (ra_pred != rpc);

    // Next-PC source selection, highest priority first.
    always_comb begin
        sel = SEL_SEQ;
        if (exc_req)
            sel = SEL_EXC;
        else if (stall)
            sel = SEL_HOLD;
        else if (is_jump)
            sel = SEL_JUMP;
        else if (is_jr || is_jalr)
            sel = SEL_REG;
        else if (branch_taken(opcode, zero_flag))
            sel = SEL_BRANCH;
    end

    // Next-PC mux; register targets always win over the RAS prediction.
    always_comb begin
        next_pc = npc;
        unique case (sel)
            SEL_EXC:    next_pc = EXC_VECTOR;
            SEL_HOLD:   next_pc = pc;
            SEL_JUMP:   next_pc = jpc;
            SEL_REG:    next_pc = rpc;
            SEL_BRANCH: next_pc = bpc;
            default:    next_pc = npc;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC;
        else
            pc <= next_pc;
    end

    // Mispredict counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mispredict_cnt <= '0;
        else if (mispredict && (mispredict_cnt != '1))
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (npc),
        .top       (ra_pred),
        .valid     (ra_pred_valid),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exc_req;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        rs_is_ra;
    logic        zero_flag;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ra_pred;
    logic        ra_pred_valid;
    logic [2:0]  ras_count;
    logic [15:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] SPECIAL = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .exc_req        (exc_req),
        .opcode         (opcode),
        .funct          (funct),
        .rs_is_ra       (rs_is_ra),
        .zero_flag      (zero_flag),
        .bpc            (bpc),
        .jpc            (jpc),
        .rpc            (rpc),
        .pc             (pc),
        .npc            (npc),
        .ra_pred        (ra_pred),
        .ra_pred_valid  (ra_pred_valid),
        .ras_count      (ras_count),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        stall = 0; exc_req = 0; opcode = SPECIAL; funct = 6'h00;
        rs_is_ra = 0; zero_flag = 0; bpc = 32'h0; jpc = 32'h0; rpc = 32'h0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1;
        tick();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ras_count); end
        checks++; if (ra_pred_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ra_pred_valid); end
        checks++; if (ra_pred !== 32'h0) begin errors++; $display("FAIL reset_ra_pred got %h want 0", ra_pred); end
        checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL reset_mis got %0d want 0", mispredict_cnt); end
        checks++; if (npc !== 32'h3004) begin errors++; $display("FAIL reset_npc got %h want %h", npc, 32'h3004); end
        rst = 0;
    endtask

    task automatic test_idle();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL idle_pc%0d got %h want %h", i, pc, exp_pc[i]); end
        end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL idle_count got %0d want 0", ras_count); end
    endtask

    task automatic test_branch();
        // pc = 0x300C from test_idle
        opcode = BEQ; zero_flag = 1; bpc = 32'h3100;
        tick();
        checks++; if (pc !== 32'h3100) begin errors++; $display("FAIL beq_taken got %h want %h", pc, 32'h3100); end
        opcode = BNE; zero_flag = 1; bpc = 32'h3200;
        tick();
        checks++; if (pc !== 32'h3104) begin errors++; $display("FAIL bne_not_taken got %h want %h", pc, 32'h3104); end
        opcode = BNE; zero_flag = 0; bpc = 32'h3200;
        tick();
        checks++; if (pc !== 32'h3200) begin errors++; $display("FAIL bne_taken got %h want %h", pc, 32'h3200); end
        opcode = BEQ; zero_flag = 0; bpc = 32'h3300;
        tick();
        checks++; if (pc !== 32'h3204) begin errors++; $display("FAIL beq_not_taken got %h want %h", pc, 32'h3204); end
        opcode = J; jpc = 32'h3500;
        tick();
        checks++; if (pc !== 32'h3500) begin errors++; $display("FAIL j_target got %h want %h", pc, 32'h3500); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL j_no_push got %0d want 0", ras_count); end
        set_idle();
    endtask

    task automatic test_jal_jr();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL jal_setup_pc got %h want %h", pc, 32'h3010); end
        opcode = JAL; jpc = 32'h3400;
        tick();
        checks++; if (pc !== 32'h3400) begin errors++; $display("FAIL jal_pc got %h want %h", pc, 32'h3400); end
        checks++; if (ra_pred !== 32'h3014) begin errors++; $display("FAIL jal_ra_pred got %h want %h", ra_pred, 32'h3014); end
        checks++; if (ra_pred_valid !== 1'b1) begin errors++; $display("FAIL jal_valid got %b want 1", ra_pred_valid); end
        opcode = SPECIAL; funct = F_JR; rs_is_ra = 1; rpc = 32'h3014;
        tick();
        checks++; if (pc !== 32'h3014) begin errors++; $display("FAIL jr_pc got %h want %h", pc, 32'h3014); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL jr_count got %0d want 0", ras_count); end
        checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL jr_hit_mis got %0d want 0", mispredict_cnt); end
        // second call from 0x3014 pushes 0x3018; return to 0x3020 mispredicts
        opcode = JAL; funct = 6'h00; rs_is_ra = 0; jpc = 32'h3400;
        tick();
        opcode = SPECIAL; funct = F_JR; rs_is_ra = 1; rpc = 32'h3020;
        tick();
        checks++; if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL jr_miss_mis got %0d want 1", mispredict_cnt); end
        checks++; if (pc !== 32'h3020) begin errors++; $display("FAIL jr_miss_pc got %h want %h", pc, 32'h3020); end
        set_idle();
    endtask

    task automatic test_ras_wrap();
        logic [31:0] exp_pop [4];
        exp_pop[0] = 32'h3014; exp_pop[1] = 32'h3010; exp_pop[2] = 32'h300C; exp_pop[3] = 32'h3008;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            opcode = JAL; jpc = npc;
            tick();
        end
        checks++; if (ras_count !== 3'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", ras_count); end
        for (int i = 0; i < 4; i++) begin
            opcode = SPECIAL; funct = F_JR; rs_is_ra = 1; rpc = exp_pop[i];
            #1;
            checks++; if (ra_pred !== exp_pop[i]) begin errors++; $display("FAIL wrap_pop%0d got %h want %h", i, ra_pred, exp_pop[i]); end
            tick();
        end
        checks++; if (ra_pred_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty_valid got %b want 0", ra_pred_valid); end
        rpc = 32'h3900;
        tick();
        checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL wrap_empty_mis got %0d want 0", mispredict_cnt); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL wrap_empty_count got %0d want 0", ras_count); end
        checks++; if (pc !== 32'h3900) begin errors++; $display("FAIL wrap_empty_pc got %h want %h", pc, 32'h3900); end
        set_idle();
    endtask

    task automatic test_jalr();
        do_reset();
        opcode = SPECIAL; funct = F_JALR; rs_is_ra = 1; rpc = 32'h3500;
        tick();
        checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL jalr_empty_count got %0d want 1", ras_count); end
        checks++; if (ra_pred !== 32'h3004) begin errors++; $display("FAIL jalr_empty_top got %h want %h", ra_pred, 32'h3004); end
        checks++; if (pc !== 32'h3500) begin errors++; $display("FAIL jalr_pc got %h want %h", pc, 32'h3500); end
        rpc = 32'h3600;
        tick();
        checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL jalr_replace_count got %0d want 1", ras_count); end
        checks++; if (ra_pred !== 32'h3504) begin errors++; $display("FAIL jalr_replace_top got %h want %h", ra_pred, 32'h3504); end
        checks++; if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL jalr_replace_mis got %0d want 1", mispredict_cnt); end
        rs_is_ra = 0; rpc = 32'h3700;
        tick();
        checks++; if (ras_count !== 3'd2) begin errors++; $display("FAIL jalr_nora_count got %0d want 2", ras_count); end
        checks++; if (ra_pred !== 32'h3604) begin errors++; $display("FAIL jalr_nora_top got %h want %h", ra_pred, 32'h3604); end
        funct = F_JR; rs_is_ra = 0; rpc = 32'h3800;
        tick();
        checks++; if (ras_count !== 3'd2) begin errors++; $display("FAIL jr_nora_count got %0d want 2", ras_count); end
        checks++; if (pc !== 32'h3800) begin errors++; $display("FAIL jr_nora_pc got %h want %h", pc, 32'h3800); end
        rs_is_ra = 1; rpc = 32'h3604;
        tick();
        checks++; if (ra_pred !== 32'h3504) begin errors++; $display("FAIL jr_pop_top got %h want %h", ra_pred, 32'h3504); end
        checks++; if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL jr_pop_mis got %0d want 1", mispredict_cnt); end
        set_idle();
    endtask

    task automatic test_stall_exc();
        do_reset();
        opcode = JAL; jpc = 32'h3400; stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL stall_pc%0d got %h want %h", i, pc, 32'h3000); end
            checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL stall_count%0d got %0d want 0", i, ras_count); end
        end
        stall = 0;
        tick();
        checks++; if (pc !== 32'h3400) begin errors++; $display("FAIL stall_release_pc got %h want %h", pc, 32'h3400); end
        checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL stall_release_count got %0d want 1", ras_count); end
        checks++; if (ra_pred !== 32'h3004) begin errors++; $display("FAIL stall_release_top got %h want %h", ra_pred, 32'h3004); end
        stall = 1; exc_req = 1;
        tick();
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_stall_pc got %h want %h", pc, 32'h4180); end
        checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL exc_stall_count got %0d want 1", ras_count); end
        stall = 0; opcode = SPECIAL; funct = F_JR; rs_is_ra = 1; rpc = 32'h1234;
        tick();
        checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_jr_pc got %h want %h", pc, 32'h4180); end
        checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL exc_jr_count got %0d want 1", ras_count); end
        checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL exc_jr_mis got %0d want 0", mispredict_cnt); end
        set_idle();
    endtask

    task automatic test_async_reset();
        // pc = 0x4180, one entry (0x3004), no mispredicts yet
        opcode = JAL; jpc = 32'h3400;
        tick();
        opcode = SPECIAL; funct = F_JR; rs_is_ra = 1; rpc = 32'h0;
        tick();
        checks++; if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL pre_rst_mis got %0d want 1", mispredict_cnt); end
        set_idle();
        stall = 1;
        #2;
        rst = 1;
        #1;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL async_rst_pc got %h want %h", pc, 32'h3000); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL async_rst_count got %0d want 0", ras_count); end
        checks++; if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_mis got %0d want 0", mispredict_cnt); end
        checks++; if (ra_pred_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", ra_pred_valid); end
        tick();
        rst = 0;
        stall = 0;
        tick();
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL post_rst_pc got %h want %h", pc, 32'h3004); end
    endtask

    initial begin
        rst = 1;
        set_idle();
        tick();
        test_reset();
        test_idle();
        test_branch();
        test_jal_jr();
        test_ras_wrap();
        test_jalr();
        test_stall_exc();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
